// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: byte FIFO, programmable baud divider and 8N1 frame FSM driving sout.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined (adds input parity_odd).
`timescale 1ns/1ps
module uart_tx_serializer #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        CLK,
   input  logic                        RSTN,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   input  logic                        tx_en,
   input  logic [DIV_WIDTH-1:0]        divisor,
`ifdef UART_TX_PARITY_EN
   input  logic                        parity_odd,
`endif
   output logic                        sout,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        thr_empty,
   output logic                        tx_idle
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0]        PTR_ONE  = AW'(1'b1);
   localparam logic [LW-1:0]        LVL_ONE  = LW'(1'b1);
   localparam logic [LW-1:0]        LVL_ZERO = LW'(1'b0);
   localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1'b1);
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO = DIV_WIDTH'(1'b0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
`ifdef UART_TX_PARITY_EN
      , ST_PARITY = 3'd3
`endif
   } state_t;

`ifdef UART_TX_PARITY_EN
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction
`endif

   state_t                 state_q, state_d;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic [7:0]             data_q, data_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [DIV_WIDTH-1:0]   baud_q, baud_d;
   logic [2:0]             bit_q, bit_d;
   logic                   sout_q, sout_d;
`ifdef UART_TX_PARITY_EN
   logic                   par_odd_q, par_odd_d;
`endif
   logic                   push, pop, frame_go, baud_tc;

   assign tx_ready   = (level_q != LVL_FULL);
   assign thr_empty  = (level_q == LVL_ZERO);
   assign tx_idle    = thr_empty && (state_q == ST_IDLE);
   assign sout       = sout_q;
   assign fifo_level = level_q;
   assign frame_go   = tx_en && !thr_empty;
   assign baud_tc    = (baud_q == (div_q - DIV_ONE));

   // FSM state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and FIFO pointer registers; reset forces sout high and empties the FIFO
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         level_q   <= LVL_ZERO;
         data_q    <= 8'h00;
         div_q     <= DIV_ONE;
         baud_q    <= DIV_ZERO;
         bit_q     <= 3'd0;
         sout_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_odd_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         data_q    <= data_d;
         div_q     <= div_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         sout_q    <= sout_d;
`ifdef UART_TX_PARITY_EN
         par_odd_q <= par_odd_d;
`endif
      end
   end

   // FIFO storage, written on accepted pushes
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr_q] <= tx_data;
      end
   end

   // FIFO pointer and occupancy update; pointers wrap naturally since depth is a power of two
   always_comb begin
      push     = tx_valid && tx_ready;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   // Next-state logic: frame sequencing, baud counting and FIFO pop at frame start
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      div_d     = div_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd_d = par_odd_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (frame_go) begin
               pop       = 1'b1;
               data_d    = mem[rd_ptr_q];
               div_d     = (divisor == DIV_ZERO) ? DIV_ONE : divisor;
               baud_d    = DIV_ZERO;
               bit_d     = 3'd0;
`ifdef UART_TX_PARITY_EN
               par_odd_d = parity_odd;
`endif
               state_d   = ST_START;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_tc) begin
               baud_d  = DIV_ZERO;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               baud_d  = baud_q + DIV_ONE;
            end
         end
         ST_DATA: begin
            if (!baud_tc) begin
               baud_d = baud_q + DIV_ONE;
            end else if (bit_q == 3'd7) begin
               baud_d = DIV_ZERO;
`ifdef UART_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end else begin
               baud_d = DIV_ZERO;
               bit_d  = bit_q + 3'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tc) begin
               baud_d  = DIV_ZERO;
               state_d = ST_STOP;
            end else begin
               baud_d  = baud_q + DIV_ONE;
            end
         end
`endif
         ST_STOP: begin
            if (!baud_tc) begin
               baud_d = baud_q + DIV_ONE;
            end else if (frame_go) begin
               // back-to-back frame: skip IDLE and re-latch the divisor
               pop       = 1'b1;
               data_d    = mem[rd_ptr_q];
               div_d     = (divisor == DIV_ZERO) ? DIV_ONE : divisor;
               baud_d    = DIV_ZERO;
               bit_d     = 3'd0;
`ifdef UART_TX_PARITY_EN
               par_odd_d = parity_odd;
`endif
               state_d   = ST_START;
            end else begin
               baud_d  = DIV_ZERO;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: serial level for the state/bit being entered, registered into sout_q
   always_comb begin
      sout_d = 1'b1;
      case (state_d)
         ST_IDLE:   sout_d = 1'b1;
         ST_START:  sout_d = 1'b0;
         ST_DATA:   sout_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: sout_d = parity_bit(data_d, par_odd_d);
`endif
         ST_STOP:   sout_d = 1'b1;
         default:   sout_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table-driven single frames, a scoreboard-fed
// cycle-exact frame monitor on sout, and hand-written back-to-back, FIFO-full and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int HMAX = 2048;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_en = 1'b0;
   logic [15:0] divisor = 16'd1;
`ifdef UART_TX_PARITY_EN
   logic        parity_odd = 1'b0;
`endif
   logic        tx_ready, sout, thr_empty, tx_idle;
   logic [3:0]  fifo_level;

   uart_tx_serializer #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
      .CLK(CLK),
      .RSTN(RSTN),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_en(tx_en),
      .divisor(divisor),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .sout(sout),
      .fifo_level(fifo_level),
      .thr_empty(thr_empty),
      .tx_idle(tx_idle)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      int         div;
      logic       odd;
   } exp_t;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] div_in;
      int          eff;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   frames_done = 0;
   bit   mon_en = 1'b0;
   logic last_par = 1'b0;
   exp_t sb[$];
   logic [3:0] lvl_hist [0:HMAX-1];
   logic       sout_hist [0:HMAX-1];
   int   cyc, f0, lows;
   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_bit(input exp_t e, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return e.data[idx-1];
      if (NBITS == 11 && idx == 9) return (^e.data) ^ e.odd;
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic exp_acc, input int eff_div, input logic odd);
      check("tx_ready_before_push", tx_ready, exp_acc);
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      if (exp_acc) sb.push_back('{d, eff_div, odd});
   endtask

   // Steps until tx_idle, recording fifo_level and sout after each edge (index 1 = first edge)
   task automatic wait_idle(input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
         lvl_hist[n]  = fifo_level;
         sout_hist[n] = sout;
      end while (!tx_idle && n < limit);
      if (!tx_idle) check("idle_timeout", tx_idle, 1'b1);
   endtask

   // Frame monitor: on a start bit, pop the expected frame and compare sout every cycle
   initial begin
      exp_t e;
      int   bad;
      bit   aborted;
      int   guard;
      forever begin
         @(negedge CLK);
         if (mon_en && sout === 1'b0) begin
            if (sb.size() == 0) begin
               check("unexpected_frame", 32'd0, 32'd1);
               guard = 0;
               while (sout === 1'b0 && guard < 64) begin
                  @(negedge CLK);
                  guard++;
               end
            end else begin
               e = sb.pop_front();
               bad = 0;
               aborted = 1'b0;
               for (int c = 0; c < NBITS * e.div; c++) begin
                  if (c > 0) @(negedge CLK);
                  if (!mon_en) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (sout !== exp_bit(e, c / e.div)) bad++;
                  if (c / e.div == 9) last_par = sout;
               end
               if (!aborted) begin
                  check($sformatf("frame_%02h_bad_cycles", e.data), bad, 0);
                  frames_done++;
               end
            end
         end
      end
   end

   initial begin
      tbl[0] = '{8'h55, 16'd4, 4};
      tbl[1] = '{8'hA3, 16'd2, 2};
      tbl[2] = '{8'h0F, 16'd2, 2};
      tbl[3] = '{8'hFF, 16'd0, 1};
      tbl[4] = '{8'h00, 16'd1, 1};
      tbl[5] = '{8'h81, 16'd3, 3};

      // reset values
      repeat (2) @(posedge CLK);
      #1;
      check("rst_sout", sout, 1'b1);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_fifo_level", fifo_level, 4'd0);
      check("rst_thr_empty", thr_empty, 1'b1);
      check("rst_tx_idle", tx_idle, 1'b1);
      RSTN = 1'b1;
      step();
      mon_en = 1'b1;

      // table-driven single frames
      tx_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         divisor = tbl[i].div_in;
         f0 = frames_done;
         push(tbl[i].data, 1'b1, tbl[i].eff, 1'b0);
         check("level_after_push", fifo_level, 4'd1);
         check("sout_before_start", sout, 1'b1);
         wait_idle(HMAX - 1, cyc);
         check("start_low_first", sout_hist[1], 1'b0);
         check("start_low_last", sout_hist[tbl[i].eff], 1'b0);
         check("data_bit0", sout_hist[1 + tbl[i].eff], tbl[i].data[0]);
         check("frame_len", cyc, NBITS * tbl[i].eff + 1);
         check("frames_one", frames_done - f0, 1);
      end

      // back-to-back frames, fifo_level 1,2,1,0
      tx_en = 1'b0;
      divisor = 16'd2;
      push(8'hA3, 1'b1, 2, 1'b0);
      check("b2b_level1", fifo_level, 4'd1);
      push(8'h0F, 1'b1, 2, 1'b0);
      check("b2b_level2", fifo_level, 4'd2);
      tx_en = 1'b1;
      wait_idle(HMAX - 1, cyc);
      check("b2b_level_pop1", lvl_hist[1], 4'd1);
      check("b2b_level_hold", lvl_hist[2 * NBITS], 4'd1);
      check("b2b_level_pop2", lvl_hist[2 * NBITS + 1], 4'd0);
      check("b2b_stop_high", sout_hist[2 * NBITS], 1'b1);
      check("b2b_no_gap", sout_hist[2 * NBITS + 1], 1'b0);
      check("b2b_total_len", cyc, 4 * NBITS + 1);

      // FIFO full with transmitter disabled
      tx_en = 1'b0;
      divisor = 16'd1;
      for (int i = 0; i < 9; i++) begin
         push(8'h10 + 8'(i), (i < 8), 1, 1'b0);
      end
      check("full_level", fifo_level, 4'd8);
      check("full_tx_ready", tx_ready, 1'b0);
      lows = 0;
      repeat (5) begin
         step();
         if (sout !== 1'b1) lows++;
      end
      check("full_sout_idle", lows, 0);
      f0 = frames_done;
      tx_en = 1'b1;
      wait_idle(HMAX - 1, cyc);
      check("full_frames_sent", frames_done - f0, 8);
      check("full_len", cyc, 8 * NBITS + 1);
      check("full_sb_empty", sb.size(), 0);

      // reset during DATA bit 3 with 3 bytes queued
      tx_en = 1'b0;
      divisor = 16'd4;
      push(8'hF0, 1'b1, 4, 1'b0);
      push(8'h11, 1'b1, 4, 1'b0);
      push(8'h22, 1'b1, 4, 1'b0);
      push(8'h33, 1'b1, 4, 1'b0);
      tx_en = 1'b1;
      repeat (18) step();
      check("mid_frame_bit3_low", sout, 1'b0);
      check("mid_frame_level", fifo_level, 4'd3);
      mon_en = 1'b0;
      RSTN = 1'b0;
      #1;
      check("abort_sout", sout, 1'b1);
      check("abort_level", fifo_level, 4'd0);
      check("abort_thr_empty", thr_empty, 1'b1);
      sb.delete();
      repeat (2) step();
      RSTN = 1'b1;
      step();
      mon_en = 1'b1;
      f0 = frames_done;
      lows = 0;
      repeat (100) begin
         step();
         if (sout !== 1'b1) lows++;
      end
      check("no_stale_sout", lows, 0);
      check("no_stale_frames", frames_done - f0, 0);
      push(8'h3C, 1'b1, 4, 1'b0);
      wait_idle(HMAX - 1, cyc);
      check("post_reset_frame", frames_done - f0, 1);

`ifdef UART_TX_PARITY_EN
      divisor = 16'd2;
      parity_odd = 1'b0;
      push(8'h07, 1'b1, 2, 1'b0);
      wait_idle(HMAX - 1, cyc);
      check("parity_even", last_par, 1'b1);
      check("parity_len", cyc, 11 * 2 + 1);
      parity_odd = 1'b1;
      push(8'h07, 1'b1, 2, 1'b1);
      wait_idle(HMAX - 1, cyc);
      check("parity_odd", last_par, 1'b0);
`endif

      repeat (3) step();
      check("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream stage of the APB UART register block: accepts the bytes software writes to the transmit holding register and drives them serially onto SOUT.
- Contains a small transmit FIFO, a programmable baud-rate divider and an 8N1 frame state machine (optional parity).
- The APB slave drives tx_valid/tx_data on each THR write; SOUT of this block connects to the chip pad.

Parameters:
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, minimum 2.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- CLK  input  1  system clock.
- RSTN  input  1  reset, asynchronous, active-low.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid; byte is accepted when tx_valid && tx_ready at a rising CLK edge.
- tx_ready  output  1  FIFO not full.
- tx_en  input  1  transmitter enable; gates the start of new frames only.
- divisor  input  DIV_WIDTH  CLK cycles per bit; 0 treated as 1.
- sout  output  1  serial output, idle high.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- thr_empty  output  1  FIFO empty.
- tx_idle  output  1  FIFO empty and FSM in IDLE (transmitter fully drained).

Behaviour:
- Reset values: sout=1, tx_ready=1, fifo_level=0, thr_empty=1, tx_idle=1, FSM=IDLE, FIFO pointers=0, baud counter=0.
- FIFO: synchronous push/pop with wrapping pointers. Push when tx_valid && tx_ready. tx_ready = (fifo_level != FIFO_DEPTH).
- A write while full is not accepted and the FIFO is unchanged. A push and a pop in the same cycle leave the level unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: if tx_en && !thr_empty, pop the head into an 8-bit shift register, latch divisor (0 becomes 1) into div_q, go to START. sout=1.
- START: sout=0 for div_q cycles.
- DATA: 8 bits, LSB first, each bit held div_q cycles. A 3-bit bit counter selects the bit; after bit 7, go to PARITY or STOP.
- STOP: sout=1 for div_q cycles.
- End of STOP: if tx_en && !thr_empty, pop and go directly to START (back-to-back frames, no idle gap, divisor re-latched). Otherwise go to IDLE.
- Baud counter: counts 0..div_q-1 within each bit and advances the FSM at terminal count. A divisor change mid-frame has no effect until the next frame.
- sout is registered. It changes on the CLK edge that enters a new state or bit.
- Latency: with an empty FIFO, IDLE and tx_en=1, a byte accepted at edge N is popped at edge N+1, so sout falls after edge N+1. Frame length without parity = 10*div_q cycles.
- tx_en deasserted mid-frame: the current frame completes normally, and no new frame starts until tx_en returns high.
- Reset asserted mid-frame: immediate abort. sout returns to 1 asynchronously and all FIFO contents are discarded.
- thr_empty = (fifo_level==0). tx_idle = thr_empty && (state==IDLE). Both are combinational from registered state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit), latched with divisor at frame start.
  - The PARITY state is inserted after DATA and held div_q cycles. The parity bit is ^data for even parity and ~^data for odd parity.
  - Frame length = 11*div_q cycles.
- Undefined: the parity_odd port and the PARITY state do not exist. DATA goes directly to STOP.

Test Plan:
- Reset, then divisor=4, tx_en=1, push 0x55 -> sout falls one cycle after the push is registered. Bits observed LSB first are 1,0,1,0,1,0,1,0, each 4 cycles, then stop high 4 cycles. tx_idle returns to 1 after 40 cycles of frame.
- Push 0xA3 and 0x0F back-to-back with divisor=2 -> two 20-cycle frames with no idle gap between stop and start. fifo_level sequence is 1,2,1,0.
- tx_en=0, push 9 bytes with FIFO_DEPTH=8 -> tx_ready drops after the 8th byte, the 9th byte is not accepted, fifo_level=8 and sout stays 1. Then set tx_en=1 -> exactly 8 frames are sent, in order.
- divisor=0 with byte 0xFF -> behaves as divisor=1: a 10-cycle frame with start low for 1 cycle.
- Assert RSTN low during DATA bit 3 of a frame with 3 bytes queued -> sout=1 and fifo_level=0 immediately. After release, no stale bytes are transmitted.
- With UART_TX_PARITY_EN defined, parity_odd=0 and byte 0x07 -> parity bit 1. With parity_odd=1 -> parity bit 0. Frame is 11*div_q cycles.
